// File: rtl/pc_unit.sv
// Program-counter stage of the single-cycle MIPS datapath.
// Holds the PC and selects the next one from PC+4, the branch target, the jump
// target and the JR register target. A boot/run/halt FSM gates fetch. A sticky
// trap catches misaligned targets. A saturating counter tallies taken branches.
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inpPcSrc,
    input  logic             inpJump,
    input  logic             inpJumpReg,
    input  logic [31:0]      inpBranchImm,
    input  logic [25:0]      inpJumpAddr,
    input  logic [31:0]      inpRegTarget,
    input  logic             inpStall,
    output logic [31:0]      pcOut,
    output logic [31:0]      pcPlus4Out,
    output logic             fetchValidOut,
    output logic             misalignOut,
    output logic [CNT_W-1:0] branchCountOut
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mis_q, mis_d;

    logic [31:0]        pc_plus4;
    logic [31:0]        br_target;
    logic [31:0]        j_target;
    logic [31:0]        next_pc;
    logic               branch_only;

    // Target arithmetic and next-PC priority: JR, then J/JAL, then branch, then PC+4.
    always_comb begin
        pc_plus4    = pc_q + 32'd4;
        br_target   = pc_plus4 + (inpBranchImm << 2);
        j_target    = {pc_plus4[31:28], inpJumpAddr, 2'b00};
        next_pc     = pc_plus4;
        if (inpJumpReg) begin
            next_pc = inpRegTarget;
        end else if (inpJump) begin
            next_pc = j_target;
        end else if (inpPcSrc) begin
            next_pc = br_target;
        end
        // Only a branch that actually steers the PC counts as taken.
        branch_only = inpPcSrc && !inpJump && !inpJumpReg;
    end

    // Next-state logic: stall outranks everything, a misaligned target halts without moving the PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (!inpStall) begin
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = HALT;
                        mis_d   = 1'b1;
                    end else begin
                        pc_d = next_pc;
                        if (branch_only && (cnt_q != {CNT_W{1'b1}})) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            HALT: begin
                mis_d = 1'b1;
            end
            default: begin
                state_d = HALT;
                mis_d   = 1'b1;
            end
        endcase
    end

    // State registers; reset aborts any activity at once.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign pcOut          = pc_q;
    assign pcPlus4Out     = pc_plus4;
    assign fetchValidOut  = (state_q == RUN);
    assign misalignOut    = mis_q;
    assign branchCountOut = cnt_q;

endmodule
